// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor computing Y = A - B one bit per clock,
//   LSB first, with a registered borrow between bit steps. A start/busy/done
//   handshake frames each operation; Y and borrow only change on the single
//   edge that enters DONE, so consumers never see a partial result.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   operation request, only looked at while idle
//   A, B    minuend / subtrahend, captured when start is accepted
//   en      clock enable for the bit steps; 0 freezes an operation in flight
//   busy    high while an operation is in progress or being reported
//   done    one-cycle pulse marking Y/borrow as freshly valid
//   Y       difference A - B modulo 2^WIDTH
//   borrow  final borrow-out, 1 when A < B (unsigned)

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             borrow
);

  // Counter must be able to hold WIDTH itself, hence WIDTH+1 states.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             br;
  logic             br_next;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             step;
  logic             last;
  logic             a0;
  logic             b0;
  logic             d;

  // Full-subtract cell on the current LSBs. The new difference bit enters
  // the result register from the top so that after WIDTH steps the first
  // bit produced has walked down to bit 0.
  always_comb begin
    a0       = ra[0];
    b0       = rb[0];
    d        = a0 ^ b0 ^ br;
    br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
    res_next = res >> 1;
    res_next[WIDTH-1] = d;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the strobes that steer the datapath.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start && en) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          step = 1'b1;
          if (cnt == LAST) begin
            last       = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. Y/borrow are loaded only together with the DONE transition,
  // which keeps them stable for the whole of the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra     <= '0;
      rb     <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      Y      <= '0;
      borrow <= 1'b0;
    end else if (accept) begin
      ra  <= A;
      rb  <= B;
      res <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else if (step) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      res <= res_next;
      br  <= br_next;
      cnt <= cnt + CW'(1);
      if (last) begin
        Y      <= res_next;
        borrow <= br_next;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
